clk_data_activity_monitor: RTL



---
 rtl/clk_data_mon_pkg.sv | 22 ++
 rtl/clk_data_sync_edge.sv | 40 ++++
 rtl/clk_data_activity_monitor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/clk_data_mon_pkg.sv
// Shared types and helpers for the clock-as-data activity monitor.
//   mon_state_e : liveness FSM encoding (IDLE=0, ACTIVE=1, LOST=2)
//   sat_inc     : saturating increment on a 32-bit carrier; callers cast to width
package clk_data_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    LOST   = 2'd2
  } mon_state_e;

  // Add inc to val, but never beyond max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic        inc,
                                          input logic [31:0] max_val);
    if (inc && (val < max_val)) begin
      return val + 32'd1;
    end
    return val;
  endfunction

endpackage

// File: rtl/clk_data_sync_edge.sv
// Multi-flop synchroniser with rising-edge detect for a single asynchronous bit.
//   clk, rst_n : sampling clock, async active-low reset
//   d_async    : asynchronous input
//   s          : synchronised level (last chain stage)
//   rise       : one-cycle pulse when s goes 0 -> 1
module clk_data_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s_dly_q;
  logic                   s_dly_d;

  // Shift chain plus one extra delay stage for edge detection.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], d_async};
    s_dly_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      s_dly_q <= s_dly_d;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = sync_q[SYNC_STAGES-1] & ~s_dly_q;

endmodule

// File: rtl/clk_data_activity_monitor.sv
// Fabric-side monitor for a clock net routed as data. Counts synchronised rising
// edges of mon_in per WINDOW-cycle window and tracks liveness with a 3-state FSM.
//   clk, rst_n    : fabric clock, async active-low reset
//   mon_in        : monitored clock-as-data signal (asynchronous)
//   enable        : monitoring enable
//   clr_lost      : single-cycle clear of lost_flag
//   edge_count    : rising edges in the last completed window (saturating)
//   count_valid   : one-cycle pulse when edge_count updates
//   state         : 0 IDLE, 1 ACTIVE, 2 LOST
//   lost_flag     : sticky, set on entry to LOST
//   level_at_loss : synchronised mon_in level captured on entry to LOST
module clk_data_activity_monitor
  import clk_data_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WINDOW      = 1024,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_in,
  input  logic             enable,
  input  logic             clr_lost,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic [1:0]       state,
  output logic             lost_flag,
  output logic             level_at_loss
);

  localparam int unsigned WCNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [CNT_W-1:0]  ACC_MAX   = {CNT_W{1'b1}};
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic sync_s;
  logic sync_rise;

  clk_data_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (mon_in),
    .s       (sync_s),
    .rise    (sync_rise)
  );

  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  mon_state_e        state_q, state_d;
  logic [CNT_W-1:0]  edge_count_q, edge_count_d;
  logic              count_valid_q, count_valid_d;
  logic              lost_flag_q, lost_flag_d;
  logic              level_q, level_d;
  logic [CNT_W-1:0]  acc_sum;

  // Window accumulation, idle tracking and liveness FSM.
  always_comb begin
    wcnt_d        = wcnt_q;
    acc_d         = acc_q;
    idle_d        = idle_q;
    state_d       = state_q;
    edge_count_d  = edge_count_q;
    count_valid_d = 1'b0;
    lost_flag_d   = lost_flag_q;
    level_d       = level_q;
    acc_sum       = CNT_W'(sat_inc(32'(acc_q), sync_rise, 32'(ACC_MAX)));

    // A coincident LOST entry below overrides this clear.
    if (clr_lost) begin
      lost_flag_d = 1'b0;
    end

    if (!enable) begin
      wcnt_d  = '0;
      acc_d   = '0;
      idle_d  = '0;
      state_d = IDLE;
    end else begin
      // A rise in the terminal cycle is folded into the closing window.
      if (wcnt_q == WCNT_LAST) begin
        wcnt_d        = '0;
        acc_d         = '0;
        edge_count_d  = acc_sum;
        count_valid_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + WCNT_ONE;
        acc_d  = acc_sum;
      end

      if ((state_q == IDLE) || sync_rise) begin
        idle_d = '0;
      end else begin
        idle_d = IDLE_W'(sat_inc(32'(idle_q), 1'b1, 32'(IDLE_MAX)));
      end

      case (state_q)
        IDLE: begin
          if (sync_rise) state_d = ACTIVE;
        end
        ACTIVE: begin
          // This cycle is the TIMEOUT-th consecutive edge-free one.
          if (!sync_rise && (idle_q == IDLE_LAST)) begin
            state_d     = LOST;
            lost_flag_d = 1'b1;
            level_d     = sync_s;
          end
        end
        LOST: begin
          if (sync_rise) state_d = ACTIVE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q        <= '0;
      acc_q         <= '0;
      idle_q        <= '0;
      state_q       <= IDLE;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
      lost_flag_q   <= 1'b0;
      level_q       <= 1'b0;
    end else begin
      wcnt_q        <= wcnt_d;
      acc_q         <= acc_d;
      idle_q        <= idle_d;
      state_q       <= state_d;
      edge_count_q  <= edge_count_d;
      count_valid_q <= count_valid_d;
      lost_flag_q   <= lost_flag_d;
      level_q       <= level_d;
    end
  end

  assign edge_count    = edge_count_q;
  assign count_valid   = count_valid_q;
  assign state         = state_q;
  assign lost_flag     = lost_flag_q;
  assign level_at_loss = level_q;

endmodule
